// File: rtl/isa_host_pkg.sv
// Shared ISA host definitions: command encodings, FSM states, phase-length clamp.
// No logic, so no latency; no flow control.
package isa_host_pkg;

    localparam logic [1:0] CMD_MEMR = 2'b00;
    localparam logic [1:0] CMD_MEMW = 2'b01;
    localparam logic [1:0] CMD_IOR  = 2'b10;
    localparam logic [1:0] CMD_IOW  = 2'b11;

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/isa_host_timer.sv
// Phase down-counter: load sets the count and dec steps it toward zero; zero is combinational.
// Load takes effect on the next edge; there is no flow control.
module isa_host_timer
    import isa_host_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/isa_host.sv
// ISA bus master: one mem/io command per bus cycle; rsp_valid comes SETUP+STROBE+1 cycles after acceptance.
// Backpressure: cmd_ready is high only in IDLE; bus_chrdy stretches the strobe up to RDY_TIMEOUT cycles.
module isa_host
    import isa_host_pkg::*;
#(
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 8,
    parameter int HOLD_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 4,
    parameter int RDY_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [19:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_aen,
    input  logic        bus_chrdy
);

    localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(at_least_one(SETUP_CYCLES) - 1);
    localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(at_least_one(STROBE_CYCLES) - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(at_least_one(HOLD_CYCLES) - 1);
    localparam logic [TMR_W-1:0] RECOV_LD  = TMR_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] TIMEOUT   = TMR_W'(RDY_TIMEOUT);

    state_t           state, next_state;
    logic [19:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [1:0]       type_q;
    logic [TMR_W-1:0] ext_q;
    logic             chrdy_s1, chrdy_s2;
    logic             rsp_valid_q, rsp_err_q;
    logic [7:0]       rsp_rdata_q;

    logic             accept, strobe_done, timed_out, ext_inc;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    isa_host_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_l  (reset_l),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Gating with reset_l keeps cmd_ready low for the whole reset pulse, not just after the first edge.
    assign cmd_ready = (state == ST_IDLE) && reset_l;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        next_state  = state;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        strobe_done = 1'b0;
        timed_out   = 1'b0;
        ext_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    next_state = ST_STROBE;
                    tmr_load   = 1'b1;
                    tmr_val    = STROBE_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                // Past the minimum width the timer rests at zero and each cycle is a wait state.
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (chrdy_s2 || (ext_q == TIMEOUT)) begin
                    strobe_done = 1'b1;
                    timed_out   = !chrdy_s2;
                    next_state  = ST_HOLD;
                    tmr_load    = 1'b1;
                    tmr_val     = HOLD_LD;
                end else begin
                    ext_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    next_state = (RECOVERY_CYCLES > 0) ? ST_RECOVER : ST_IDLE;
                    tmr_load   = (RECOVERY_CYCLES > 0);
                    tmr_val    = RECOV_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (tmr_zero) begin
                    next_state = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            type_q      <= CMD_MEMR;
            ext_q       <= '0;
            chrdy_s1    <= 1'b1;
            chrdy_s2    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= next_state;
            chrdy_s1    <= bus_chrdy;
            chrdy_s2    <= chrdy_s1;
            rsp_valid_q <= strobe_done;
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                type_q  <= cmd_type;
                ext_q   <= '0;
            end else if (ext_inc) begin
                ext_q <= ext_q + 1'b1;
            end
            // Read data is sampled on the edge that ends the strobe, while the line is still low.
            if (strobe_done) begin
                rsp_err_q <= timed_out;
                if (timed_out)
                    rsp_rdata_q <= 8'hFF;
                else if (type_q[0])
                    rsp_rdata_q <= 8'h00;
                else
                    rsp_rdata_q <= bus_d_in;
            end
        end
    end

    logic on_bus, strobing;
    assign on_bus   = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
    assign strobing = (state == ST_STROBE);

    assign bus_a      = addr_q;
    assign bus_aen    = !on_bus;
    assign bus_d_oe   = on_bus && type_q[0];
    assign bus_d_out  = bus_d_oe ? wdata_q : 8'h00;
    assign bus_memr_l = !(strobing && (type_q == CMD_MEMR));
    assign bus_memw_l = !(strobing && (type_q == CMD_MEMW));
    assign bus_ior_l  = !(strobing && (type_q == CMD_IOR));
    assign bus_iow_l  = !(strobing && (type_q == CMD_IOW));

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_isa_host.sv
// Directed bench for isa_host with default timing: vector table plus back-to-back and mid-strobe reset sequences.
module tb_isa_host;
    import isa_host_pkg::*;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_type;
    logic [19:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [19:0] bus_a;
    logic [7:0]  bus_d_out, bus_d_in;
    logic        bus_d_oe, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l, bus_aen, bus_chrdy;

    isa_host dut (
        .clk(clk), .reset_l(reset_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_ior_l(bus_ior_l),
        .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_chrdy(bus_chrdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          lo_from;     // strobe cycle at which bus_chrdy is pulled low (0 = never)
        int          lo_to;       // strobe cycle at which bus_chrdy is released (0 = never)
        int          exp_strobe;
        int          exp_lat;
        int          exp_oe;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int         first_strobe, strobe_len, bad_strobe, lat, rsp_cnt;
        int         oe_cnt, dout_bad, aen_low, addr_bad, ready_cyc;
        logic [7:0] rdata;
        logic       err;
    } res_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] strobe_mask(input logic [1:0] t);
        case (t)
            CMD_MEMR: return 4'b0111;
            CMD_MEMW: return 4'b1011;
            CMD_IOR:  return 4'b1101;
            default:  return 4'b1110;
        endcase
    endfunction

    function automatic int lows(input logic [3:0] s);
        return int'(!s[0]) + int'(!s[1]) + int'(!s[2]) + int'(!s[3]);
    endfunction

    // Issues one command from IDLE; cycle 0 is the acceptance cycle, run ends when cmd_ready returns.
    task automatic run_cmd(input vec_t v, output res_t r);
        int cyc, sc;
        logic [3:0] s;
        r = '{default: 0};
        bus_d_in = v.din; cmd_type = v.typ; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; sc = 0;
        while (cyc < 600) begin
            s = {bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l};
            if (s == strobe_mask(v.typ)) begin
                sc++;
                if (r.first_strobe == 0) r.first_strobe = cyc;
                if (sc == v.lo_from) bus_chrdy = 1'b0;
                if (sc == v.lo_to)   bus_chrdy = 1'b1;
            end else if (s != 4'hF) begin
                r.bad_strobe++;
            end
            if (!bus_aen) begin
                r.aen_low++;
                if (bus_a != v.addr) r.addr_bad++;
            end
            if (bus_d_oe) begin
                r.oe_cnt++;
                if (bus_d_out != v.wdata) r.dout_bad++;
            end
            if (rsp_valid) begin
                r.rsp_cnt++;
                if (r.rsp_cnt == 1) begin r.lat = cyc; r.rdata = rsp_rdata; r.err = rsp_err; end
            end
            if (cmd_ready) begin r.ready_cyc = cyc; break; end
            @(negedge clk);
            cyc++;
        end
        r.strobe_len = sc;
        bus_chrdy = 1'b1;
    endtask

    vec_t vecs[6];
    res_t r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, rsp1, cyc, ovl, nrsp;

        reset_l = 1'b0; cmd_valid = 1'b0; cmd_type = CMD_MEMR; cmd_addr = '0;
        cmd_wdata = '0; bus_d_in = '0; bus_chrdy = 1'b1;

        //         typ       addr       wdata  din    from to  strb lat  oe  rdata  err
        vecs[0] = '{CMD_MEMW, 20'hB0000, 8'h41, 8'h00, 0,   0,  8,   11,  12, 8'h00, 1'b0};
        vecs[1] = '{CMD_IOR,  20'h003BA, 8'h00, 8'h89, 0,   0,  8,   11,  0,  8'h89, 1'b0};
        vecs[2] = '{CMD_IOW,  20'h00378, 8'h5A, 8'h00, 0,   0,  8,   11,  12, 8'h00, 1'b0};
        vecs[3] = '{CMD_MEMR, 20'hC8000, 8'h00, 8'h3C, 0,   0,  8,   11,  0,  8'h3C, 1'b0};
        vecs[4] = '{CMD_IOR,  20'h00201, 8'h00, 8'hA7, 5,   10, 12,  15,  0,  8'hA7, 1'b0};
        vecs[5] = '{CMD_MEMR, 20'hF0000, 8'h00, 8'h12, 1,   0,  263, 266, 0,  8'hFF, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_strobes", {bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l}, 4'hF);
        chk("rst_aen", bus_aen, 1);
        chk("rst_bus_a", bus_a, 0);
        chk("rst_oe", bus_d_oe, 0);
        chk("rst_d_out", bus_d_out, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(negedge clk);
        reset_l = 1'b1;
        #1 chk("rel_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i], r);
            chk($sformatf("v%0d_first_strobe", i), r.first_strobe, 3);
            chk($sformatf("v%0d_strobe_len", i), r.strobe_len, vecs[i].exp_strobe);
            chk($sformatf("v%0d_bad_strobe", i), r.bad_strobe, 0);
            chk($sformatf("v%0d_latency", i), r.lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_rsp_pulses", i), r.rsp_cnt, 1);
            chk($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), r.err, vecs[i].exp_err);
            chk($sformatf("v%0d_oe_cycles", i), r.oe_cnt, vecs[i].exp_oe);
            chk($sformatf("v%0d_dout_bad", i), r.dout_bad, 0);
            chk($sformatf("v%0d_aen_low", i), r.aen_low, vecs[i].exp_lat + 1);
            chk($sformatf("v%0d_addr_bad", i), r.addr_bad, 0);
            chk($sformatf("v%0d_ready_back", i), r.ready_cyc, vecs[i].exp_lat + 6);
        end

        // Back-to-back: cmd_valid held; second acceptance HOLD+RECOVERY = 6 cycles after first rsp_valid.
        cmd_type = CMD_IOW; cmd_addr = 20'h00300; cmd_wdata = 8'hC3; cmd_valid = 1'b1;
        acc1 = -1; acc2 = -1; rsp1 = -1; ovl = 0; cyc = 0;
        while (cyc < 100 && acc2 < 0) begin
            if (cmd_valid && cmd_ready) begin
                if (acc1 < 0) acc1 = cyc; else acc2 = cyc;
            end
            if (rsp_valid && rsp1 < 0) rsp1 = cyc;
            if (lows({bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l}) > 1) ovl++;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            if (lows({bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l}) > 1) ovl++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_acc", acc1, 0);
        chk("b2b_first_rsp", rsp1, 11);
        chk("b2b_gap", acc2 - rsp1, 6);
        chk("b2b_overlap", ovl, 0);
        chk("b2b_idle_again", cmd_ready, 1);

        // Reset during the strobe of a memw.
        cmd_type = CMD_MEMW; cmd_addr = 20'hC0000; cmd_wdata = 8'h77; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (bus_memw_l && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rst_mid_saw_strobe", bus_memw_l, 0);
        repeat (2) @(negedge clk);
        reset_l = 1'b0;
        #1;
        chk("rst_mid_memw_l", bus_memw_l, 1);
        chk("rst_mid_aen", bus_aen, 1);
        chk("rst_mid_oe", bus_d_oe, 0);
        chk("rst_mid_bus_a", bus_a, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 0);
        nrsp = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        reset_l = 1'b1;
        #1 chk("rst_mid_ready_after", cmd_ready, 1);
        if (rsp_valid) nrsp++;
        @(negedge clk);
        if (rsp_valid) nrsp++;
        chk("rst_mid_no_rsp", nrsp, 0);
        run_cmd(vecs[0], r);
        chk("post_rst_strobe_len", r.strobe_len, 8);
        chk("post_rst_latency", r.lat, 11);
        chk("post_rst_rsp_pulses", r.rsp_cnt, 1);
        chk("post_rst_err", r.err, 0);
        chk("post_rst_oe_cycles", r.oe_cnt, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
